yn_capture_buffer: RTL and testbench
====================================

// Module: yn_capture_buffer
// PURPOSE
//  Sink-side companion to the FIR filter: captures DEPTH consecutive yn samples into on-chip RAM.
//  Replays them over a valid/ready read port for comparison against golden output or for export.
//  Sits directly on the filter yn output. Optional skip count hides the filter pipeline latency.
// PARAMETERS
//  DATA_W  16   sample width, two's complement (matches filter yn)
//  DEPTH   256  samples captured per run; power of two, >=2
//  SKIP    0    valid samples discarded after start, before capture (0..65535)
// PORTS
//  clk         in   1              single clock, rising edge
//  rst_n       in   1              asynchronous active-low reset
//  start       in   1              1-cycle pulse: arm a capture run (ignored unless IDLE)
//  abort       in   1              return to IDLE from any state next cycle
//  sample_in   in   DATA_W         filter yn, signed
//  sample_vld  in   1              sample_in valid this cycle (tie 1 for one sample/clock)
//  busy        out  1              high in every state except IDLE
//  done        out  1              1-cycle pulse after last readout transfer
//  rd_data     out  DATA_W         captured sample, oldest first
//  rd_valid    out  1              rd_data valid
//  rd_ready    in   1              consumer accepts rd_data
//  rd_last     out  1              qualifies rd_data index DEPTH-1
//  peak_abs    out  DATA_W         max |sample| of run (only with YN_CAP_PEAK_EN, else 0)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, rd_valid, rd_last = 0; rd_data = 0; counters = 0; peak_abs = 0.
//   RAM contents are not reset.
//  FSM: IDLE -start-> SKIP (SKIP>0) or CAPT (SKIP==0).
//   SKIP: count sample_vld cycles; on the SKIP-th -> CAPT (that sample is discarded).
//   CAPT: each sample_vld writes sample_in to mem[wr_ptr], wr_ptr++.
//    On write DEPTH-1 -> PREF. No write when sample_vld=0.
//   PREF: one cycle, registered RAM read of address 0 -> DRAIN.
//   DRAIN: rd_valid=1. Transfer = rd_valid & rd_ready.
//    rd_data/rd_valid/rd_last hold while rd_ready=0.
//    After a transfer the next word presents the following cycle: zero bubbles under rd_ready=1,
//     via read-address lookahead (rd_ptr+1 on transfer).
//    Transfer with rd_last=1 -> DONE.
//   DONE: done=1 for exactly one cycle, rd_valid=0 -> IDLE.
//  Latency: last CAPT write -> first rd_valid = 2 cycles. Full drain at rd_ready=1 = DEPTH cycles.
//  start while busy: ignored, no effect on counters.
//  abort: highest priority over start and all transitions.
//   Next cycle state=IDLE, rd_valid=0, counters cleared, no done pulse.
//  start and abort in the same IDLE cycle: abort wins, stays IDLE.
//  Pointers are log2(DEPTH) bits and never wrap inside a run; state exits at DEPTH-1.
//  sample_in is captured unmodified; no saturation or rescaling.
// CONFIGURATION
//  YN_CAP_PEAK_EN defined: register tracks max |sample_in| over captured (not skipped) samples.
//   Cleared on start. |-2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1.
//   peak_abs is final from PREF onward and holds until the next start or reset.
//  Not defined: no peak logic is built; peak_abs tied to 0.
// STRUCTURE
//  Package yn_cap_pkg:
//   - state enum {IDLE, SKIP, CAPT, PREF, DRAIN, DONE}
//   - DATA_W default localparam
//   - abs-with-saturation function
//  Sub-module yn_cap_ram: simple dual-port RAM, DEPTH x DATA_W.
//   Sync write port, sync read port with 1-cycle registered output.
//  Top holds the FSM, skip/write/read counters, output registers and the optional peak register.
// TESTING
//  1 Reset mid-DRAIN (rst_n low at transfer 10) -> next edge all outputs 0, IDLE.
//    A new start + 256 samples replays correctly.
//  2 SKIP=0, start, sample_in = 0..255 every cycle, rd_ready=1
//    -> rd_data 0..255 on consecutive cycles, rd_last on 255.
//    First rd_valid 2 cycles after write 255; done pulse one cycle after.
//  3 SKIP=4, sample_in ramp 100.. -> first rd_data=104, last=359.
//  4 rd_ready random 50%, sample_vld toggling -> no loss or duplication.
//    Order matches written samples; rd_data stable while stalled.
//  5 start pulsed during CAPT and DRAIN -> ignored.
//    abort at CAPT write 100 -> IDLE next cycle, no done.
//    Fresh start then captures a full 256.
//  6 YN_CAP_PEAK_EN: samples {5,-300,-32768,7,...0} -> peak_abs=32767.
//    Without the macro -> peak_abs=0.

Source files
------------

// File: rtl/yn_cap_pkg.sv
// Shared types and helpers for the yn capture buffer: FSM state encoding,
// default sample width and a saturating absolute-value function.
package yn_cap_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CAPT,
    ST_PREF,
    ST_DRAIN,
    ST_DONE
  } cap_state_t;

  // |x| for a w-bit two's complement value held sign-extended in x;
  // the most negative value maps to the largest positive one.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x,
                                          input int unsigned w);
    logic [31:0] mag;
    logic [31:0] lim;
    mag = x[31] ? 32'(-x) : 32'(x);
    lim = (32'd1 << (w - 1)) - 32'd1;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/yn_cap_ram.sv
// Simple dual-port RAM, DEPTH x DATA_W: synchronous write, synchronous read
// with an enable-gated output register (holds its value while i_re is low).
module yn_cap_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset; array contents stay undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/yn_capture_buffer.sv
// Captures DEPTH filter yn samples (after SKIP discarded ones) into RAM and
// replays them over a valid/ready port. Optional peak tracker: YN_CAP_PEAK_EN.
module yn_capture_buffer
  import yn_cap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  parameter int SKIP   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_vld,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic [DATA_W-1:0]        peak_abs
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [15:0]   SKIP_LAST = (SKIP > 0) ? 16'(SKIP - 1) : 16'd0;

  cap_state_t  r_state;
  cap_state_t  w_state_nxt;
  logic [15:0] r_skip_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic        r_rd_valid;
  logic        r_rd_last;
  logic        r_done;
  logic        w_start_ok;
  logic        w_xfer;
  logic        w_wr_en;
  logic        w_rd_en;

  assign w_start_ok = start & ~abort & (r_state == ST_IDLE);
  assign w_xfer     = r_rd_valid & rd_ready;
  assign w_wr_en    = ~abort & (r_state == ST_CAPT) & sample_vld;
  // Read-address lookahead: fetch the next word on the same edge that
  // retires the current one, so back-to-back transfers have no bubbles.
  assign w_rd_en    = ~abort & ((r_state == ST_PREF) |
                      ((r_state == ST_DRAIN) & w_xfer & ~r_rd_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = (SKIP > 0) ? ST_SKIP : ST_CAPT;
      ST_SKIP:  if (sample_vld && r_skip_cnt == SKIP_LAST) w_state_nxt = ST_CAPT;
      ST_CAPT:  if (sample_vld && r_wr_ptr == LAST_ADDR) w_state_nxt = ST_PREF;
      ST_PREF:  w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_xfer && r_rd_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
    end else if (abort) begin
      r_skip_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) & w_xfer & r_rd_last;
      if (r_state == ST_SKIP && sample_vld)
        r_skip_cnt <= (r_skip_cnt == SKIP_LAST) ? 16'd0 : r_skip_cnt + 16'd1;
      if (w_wr_en)
        r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
      if (r_state == ST_PREF)
        r_rd_valid <= 1'b1;
      if (w_rd_en) begin
        r_rd_ptr  <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
        r_rd_last <= (r_rd_ptr == LAST_ADDR);
      end
      if (r_state == ST_DRAIN && w_xfer && r_rd_last) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

  yn_cap_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (sample_in),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;

`ifdef YN_CAP_PEAK_EN
  logic signed [31:0] w_samp_ext;
  logic [DATA_W-1:0]  w_samp_abs;
  logic [DATA_W-1:0]  r_peak;

  assign w_samp_ext = 32'(sample_in);
  assign w_samp_abs = DATA_W'(abs_sat(w_samp_ext, DATA_W));

  // Only written samples contribute, so the value is final once in PREF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_peak <= '0;
    else if (w_start_ok)                       r_peak <= '0;
    else if (w_wr_en && w_samp_abs > r_peak)   r_peak <= w_samp_abs;
  end

  assign peak_abs = r_peak;
`else
  assign peak_abs = '0;
`endif

endmodule

// File: tb/tb_yn_capture_buffer.sv
// Directed bench for yn_capture_buffer: two instances (SKIP=0 and SKIP=4)
// with a scoreboard queue per instance checked on every read transfer.
module tb_yn_capture_buffer;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic abort = 1'b0;
  logic sample_vld = 1'b0;
  logic rd_ready = 1'b0;
  logic signed [15:0] sample_in = '0;

  logic busy0, done0, rd_valid0, rd_last0;
  logic [15:0] rd_data0, peak0;
  logic busy1, done1, rd_valid1, rd_last1;
  logic [15:0] rd_data1, peak1;

  int checks = 0;
  int failures = 0;
  int xfer0 = 0;
  int xfer1 = 0;
  ent_t q0[$];
  ent_t q1[$];
  logic hold0 = 1'b0;
  logic [15:0] hold_d0 = '0;

  always #5 clk = ~clk;

  yn_capture_buffer #(.DATA_W(16), .DEPTH(256), .SKIP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .sample_in(sample_in), .sample_vld(sample_vld), .busy(busy0), .done(done0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready),
    .rd_last(rd_last0), .peak_abs(peak0)
  );

  yn_capture_buffer #(.DATA_W(16), .DEPTH(256), .SKIP(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .sample_in(sample_in), .sample_vld(sample_vld), .busy(busy1), .done(done1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready),
    .rd_last(rd_last1), .peak_abs(peak1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input int idx, input logic [15:0] d);
    ent_t e;
    e.d = d;
    e.last = (idx == 255);
    q0.push_back(e);
  endtask

  task automatic push1(input int idx, input logic [15:0] d);
    ent_t e;
    e.d = d;
    e.last = (idx == 255);
    q1.push_back(e);
  endtask

  // Start DUT0 and feed 256 consecutive samples base + i*step.
  task automatic run_ramp0(input int base, input int step, input int start_at);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sample_in = 16'(base + i * step);
      sample_vld = 1'b1;
      start0 = (i == start_at);
      push0(i, sample_in);
      tick();
    end
    start0 = 1'b0;
    sample_vld = 1'b0;
  endtask

  task automatic wait_done0(input int budget, output int cycles);
    cycles = 0;
    while (!done0 && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("done0_seen", done0, 1);
    tick();
    chk("done0_one_cycle", done0, 0);
    chk("busy0_after_done", busy0, 0);
    chk("q0_drained", q0.size(), 0);
  endtask

  always @(negedge clk) begin
    if (hold0) begin
      hold0 = 1'b0;
      chk("stall_valid_held", rd_valid0, 1);
      chk("stall_data_held", rd_data0, hold_d0);
    end
    if (rd_valid0 && rd_ready) begin
      chk("q0_has_entry", (q0.size() > 0), 1);
      if (q0.size() > 0) begin
        ent_t e;
        e = q0.pop_front();
        chk("rd_data0", rd_data0, e.d);
        chk("rd_last0", rd_last0, e.last);
      end
      xfer0++;
    end else if (rd_valid0) begin
      hold0 = 1'b1;
      hold_d0 = rd_data0;
    end
    if (rd_valid1 && rd_ready) begin
      chk("q1_has_entry", (q1.size() > 0), 1);
      if (q1.size() > 0) begin
        ent_t e;
        e = q1.pop_front();
        chk("rd_data1", rd_data1, e.d);
        chk("rd_last1", rd_last1, e.last);
      end
      xfer1++;
    end
  end

  initial begin
    int n;
    int cyc;
    int base;
    logic [15:0] pk_ramp;
    logic [15:0] pk_exp;
    logic signed [15:0] pk_pat [4];

`ifdef YN_CAP_PEAK_EN
    pk_ramp = 16'd255;
    pk_exp  = 16'd32767;
`else
    pk_ramp = 16'd0;
    pk_exp  = 16'd0;
`endif

    // Reset state
    tick();
    tick();
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_rd_valid", rd_valid0, 0);
    chk("rst_rd_last", rd_last0, 0);
    chk("rst_rd_data", rd_data0, 0);
    chk("rst_peak", peak0, 0);
    rst_n = 1'b1;
    rd_ready = 1'b1;
    tick();

    // Ramp 0..255, SKIP=0, latency and zero-bubble drain
    run_ramp0(0, 1, -1);
    chk("pref_busy", busy0, 1);
    chk("pref_no_valid", rd_valid0, 0);
    chk("peak_ramp", peak0, pk_ramp);
    tick();
    chk("first_valid_latency", rd_valid0, 1);
    chk("first_data", rd_data0, 0);
    wait_done0(400, n);
    chk("drain_cycles", n, 256);

    // SKIP=4, ramp from 100
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 260; i++) begin
      sample_in = 16'(100 + i);
      sample_vld = 1'b1;
      if (i >= 4) push1(i - 4, sample_in);
      tick();
    end
    sample_vld = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("done1_seen", done1, 1);
    chk("q1_drained", q1.size(), 0);
    chk("xfer1_count", xfer1, 256);

    // Random backpressure and sparse sample_vld
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 256 && cyc < 5000) begin
      sample_vld = 1'($urandom_range(0, 1));
      sample_in = 16'($urandom);
      if (sample_vld) begin
        push0(n, sample_in);
        n++;
      end
      rd_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    sample_vld = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 3000) begin
      rd_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    rd_ready = 1'b1;
    chk("rand_done_seen", done0, 1);
    tick();
    chk("rand_q0_drained", q0.size(), 0);

    // Start ignored during CAPT and DRAIN
    run_ramp0(-500, 3, 50);
    tick();
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done0(400, n);

    // Abort at write 100, then a fresh full capture
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      sample_in = 16'(i);
      sample_vld = 1'b1;
      abort = (i == 100);
      tick();
    end
    abort = 1'b0;
    sample_vld = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_rd_valid", rd_valid0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", done0, 0);
      tick();
    end
    start0 = 1'b1;
    abort = 1'b1;
    tick();
    start0 = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy0, 0);
    run_ramp0(7, 5, -1);
    wait_done0(400, n);

    // Reset mid-DRAIN at transfer 10, then replay
    run_ramp0(1000, -7, -1);
    base = xfer0;
    cyc = 0;
    while (xfer0 < base + 10 && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("reached_xfer10", xfer0 - base, 10);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_rd_valid", rd_valid0, 0);
    chk("mid_rst_rd_last", rd_last0, 0);
    chk("mid_rst_rd_data", rd_data0, 0);
    chk("mid_rst_done", done0, 0);
    q0.delete();
    hold0 = 1'b0;
    rst_n = 1'b1;
    tick();
    run_ramp0(-20000, 151, -1);
    wait_done0(400, n);

    // Peak: 5, -300, -32768, 7, then zeros
    pk_pat[0] = 16'sd5;
    pk_pat[1] = -16'sd300;
    pk_pat[2] = -16'sd32768;
    pk_pat[3] = 16'sd7;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sample_in = (i < 4) ? pk_pat[i] : 16'sd0;
      sample_vld = 1'b1;
      push0(i, sample_in);
      tick();
    end
    sample_vld = 1'b0;
    chk("peak_abs", peak0, pk_exp);
    wait_done0(400, n);
    chk("peak_abs_held", peak0, pk_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
